vx_afu_ctrl_queued: RTL and testbench
=====================================

# vx_afu_ctrl_queued

Parametrised AXI4-Lite control slave for the XRT AFU. It generalises the kernel control register file with:
- independent AW/W acceptance and SLVERR responses;
- sticky clear-on-read `ap_done` and level-tracked interrupt status;
- a bank of 64-bit user argument registers;
- a DCR write FIFO with ready/valid backpressure toward the GPU.

It sits between the host shell's control port and the Vortex top level.

## Interface
- S_AXI_ADDR_WIDTH, 8: byte address width; only the low 8 bits are decoded.
- S_AXI_DATA_WIDTH, 32: fixed at 32; other values are an elaboration error.
- DCR_FIFO_DEPTH, 4: DCR queue entries; power of two, ≥2.
- NUM_USER_REGS, 4: 64-bit user registers; 1..8.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_axi_awvalid/awaddr/awready, s_axi_wvalid/wdata/wstrb/wready, s_axi_bvalid/bresp/bready, s_axi_arvalid/araddr/arready, s_axi_rvalid/rdata/rresp/rready: standard AXI4-Lite slave, widths from the parameters.
- ap_start  out  1  kernel start level
- ap_reset  out  1  one-cycle kernel reset pulse
- ap_done, ap_ready, ap_idle  in  1 each  kernel status
- interrupt  out  1  level interrupt
- ap_ctrl_read  out  1  pulse on an R handshake of address 0x00
- dev_caps, isa_caps  in  64 each  static capability words
- dcr_wr_valid  out  1; dcr_wr_ready  in  1
- dcr_wr_addr  out  VX_DCR_ADDR_WIDTH; dcr_wr_data  out  VX_DCR_DATA_WIDTH
- user_regs  out  64*NUM_USER_REGS  flattened; register i is at bits [64i+63:64i]

## Operation
Address map:
- 0x00 CTRL: bit0 start (RW), bit1 done (RO, COR), bit2 idle, bit3 ready, bit4 reset (WO), bit7 auto_restart (RW).
- 0x04 GIE [0]; 0x08 IER [1:0]; 0x0C ISR [1:0], toggle-on-write.
- 0x10/0x14 dev_caps lo/hi, RO. 0x18/0x1C isa_caps lo/hi, RO.
- 0x20 DCR address, RW. 0x24 DCR value, WO; a write pushes {addr, value} to the FIFO.
- 0x28 DCR status, RO: [15:0] occupancy, [16] empty, [17] full.
- 0x40+8i / 0x44+8i: user_reg[i] lo/hi, RW, byte-masked by wstrb.

Write channel:
- AW and W are captured in separate holding registers, in either order or in the same cycle.
- awready = ~aw_held & ~bvalid & ~reset; wready = ~w_held & ~bvalid & ~reset.
- Commit happens in the cycle both are held. A commit to 0x24 additionally requires FIFO not full; otherwise it waits with both holding registers occupied.
- bresp = SLVERR (2'b10) for unmapped or RO addresses; state is unchanged. Otherwise OKAY.
- Writing 0 to CTRL bit0 has no effect. Bit7 write sets or clears auto_restart.
- Bit4 pulses ap_reset, flushes the DCR FIFO, and clears ap_start and the done latch.

Read channel:
- arready = ~rvalid & ~reset.
- rresp = SLVERR with rdata = 0 for unmapped addresses (includes 0x24 and user indices ≥ NUM_USER_REGS).

Kernel control:
- ap_start is cleared on ap_ready unless auto_restart = 1.
- The done latch is set on ap_done. It is cleared on the R handshake of a CTRL read that returned bit1 = 1. Set wins over a simultaneous clear.
- ISR[k] is set on any cycle where IER[k] and its event (k0 = ap_done, k1 = ap_ready) are both high. Set wins over a simultaneous toggle.
- interrupt = GIE & |ISR.

DCR FIFO:
- dcr_wr_valid = ~empty; dcr_wr_addr/data are driven from the head entry.
- Pop on valid & ready. Push and pop may occur in the same cycle unless full; a full FIFO blocks the push even if a pop occurs that cycle.

## Timing
- Reset values: all outputs 0, including all ready signals while reset is high; FIFO empty; all registers 0.
- Write: AW and W fire at cycle T → register update at the end of T+1 → bvalid at T+2, held until bready.
- A 0x24 commit with FIFO full stalls; bvalid follows 1 cycle after the commit.
- A pushed entry is visible on dcr_wr_valid in the cycle after commit.
- Read: AR fires at T → rvalid, rdata and rresp registered at T+1, held stable until rready.
- Status fields are sampled at T.
- Reset asserted mid-transaction drops all pending AW, W, B and R state and the FIFO contents. No response is issued.

## Test plan
1. W fires 3 cycles before AW to 0x40, data 0xDEADBEEF, wstrb 0x3 → bresp OKAY; user_reg[0][31:0] = 0x0000BEEF; a read of 0x40 returns 0x0000BEEF.
2. dcr_wr_ready held 0; 5 pairs of 0x20/0x24 writes with DEPTH=4 → 4 OKAYs; the fifth W stalls and 0x28 reads 0x2_0004. Raise ready → 5 entries drain in order, addr/data matching, then 0x28 reads 0x1_0000.
3. Pulse ap_done with IER = 1 and GIE = 1 → interrupt rises 1 cycle later. CTRL read returns bit1 = 1; a second read returns bit1 = 0; ap_ctrl_read pulses on each read. Write ISR 0x1 → interrupt falls.
4. Read 0x30 and write 0x10 → SLVERR on both; rdata = 0; dev_caps is unaffected.
5. Write CTRL 0x81 with ap_ready pulsed → ap_start stays 1. Write CTRL 0x10 → ap_reset high for exactly 1 cycle, ap_start = 0, FIFO empty.
6. Assert reset while bvalid is high and a FIFO entry is pending → bvalid, dcr_wr_valid and interrupt are 0 in the next cycle, and all readies are 0 until reset deasserts.

Source files
------------

// File: rtl/vx_afu_ctrl_queued_if.sv
// rtl/vx_afu_ctrl_queued_if.sv - AXI4-Lite control port bundle for the AFU control slave
interface vx_afu_ctrl_queued_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vx_afu_ctrl_queued.sv
// rtl/vx_afu_ctrl_queued.sv - AXI4-Lite AFU control slave with user registers and DCR write queue
module vx_afu_ctrl_queued #(
    parameter int S_AXI_ADDR_WIDTH  = 8,
    parameter int S_AXI_DATA_WIDTH  = 32,
    parameter int DCR_FIFO_DEPTH    = 4,
    parameter int NUM_USER_REGS     = 4,
    parameter int VX_DCR_ADDR_WIDTH = 12,
    parameter int VX_DCR_DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    vx_afu_ctrl_queued_if.slave            s_axi,
    output logic                           ap_start,
    output logic                           ap_reset,
    input  logic                           ap_done,
    input  logic                           ap_ready,
    input  logic                           ap_idle,
    output logic                           interrupt,
    output logic                           ap_ctrl_read,
    input  logic [63:0]                    dev_caps,
    input  logic [63:0]                    isa_caps,
    output logic                           dcr_wr_valid,
    input  logic                           dcr_wr_ready,
    output logic [VX_DCR_ADDR_WIDTH-1:0]   dcr_wr_addr,
    output logic [VX_DCR_DATA_WIDTH-1:0]   dcr_wr_data,
    output logic [64*NUM_USER_REGS-1:0]    user_regs
);
    generate
        if (S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
            $error("S_AXI_DATA_WIDTH must be 32");
        end
        if (S_AXI_ADDR_WIDTH < 8) begin : g_bad_addr_width
            $error("S_AXI_ADDR_WIDTH must be at least 8");
        end
        if (DCR_FIFO_DEPTH < 2 || (DCR_FIFO_DEPTH & (DCR_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DCR_FIFO_DEPTH must be a power of two >= 2");
        end
        if (NUM_USER_REGS < 1 || NUM_USER_REGS > 8) begin : g_bad_user_regs
            $error("NUM_USER_REGS must be 1..8");
        end
        if (VX_DCR_ADDR_WIDTH > 32 || VX_DCR_DATA_WIDTH > 32) begin : g_bad_dcr_width
            $error("DCR address/data widths must not exceed 32");
        end
    endgenerate

    localparam int            PW     = $clog2(DCR_FIFO_DEPTH);
    localparam logic [3:0]    NUM_UR = 4'(NUM_USER_REGS);
    localparam logic [1:0]    OKAY   = 2'b00;
    localparam logic [1:0]    SLVERR = 2'b10;

    logic        aw_held, w_held;
    logic [7:0]  aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q, r_is_ctrl_q, r_ctrl_done_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ap_start_q, auto_restart_q, done_q, ap_reset_q, gie_q;
    logic [1:0]  ier_q, isr_q;
    logic [VX_DCR_ADDR_WIDTH-1:0] dcr_addr_q;
    logic [63:0] user_q [NUM_USER_REGS];

    logic [VX_DCR_ADDR_WIDTH-1:0] fifo_addr [DCR_FIFO_DEPTH];
    logic [VX_DCR_DATA_WIDTH-1:0] fifo_data [DCR_FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr, fifo_count;
    logic        fifo_empty, fifo_full, push, pop;

    logic        aw_fire, w_fire, ar_fire, r_fire, commit, wr_ok, wr_user, rd_err;
    logic [31:0] rd_data;
    logic [7:0]  ar_addr;
    logic [1:0]  irq_event;

    assign s_axi.awready = ~aw_held & ~bvalid_q & ~reset;
    assign s_axi.wready  = ~w_held & ~bvalid_q & ~reset;
    assign s_axi.arready = ~rvalid_q & ~reset;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign aw_fire = s_axi.awvalid & s_axi.awready;
    assign w_fire  = s_axi.wvalid & s_axi.wready;
    assign ar_fire = s_axi.arvalid & s_axi.arready;
    assign r_fire  = rvalid_q & s_axi.rready;
    assign ar_addr = s_axi.araddr[7:0];

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == (PW+1)'(DCR_FIFO_DEPTH));
    // A DCR value write parks in the holding registers until the queue has room
    assign commit     = aw_held & w_held & ~((aw_addr_q == 8'h24) & fifo_full);
    assign push       = commit & (aw_addr_q == 8'h24);
    assign pop        = ~fifo_empty & dcr_wr_ready;
    assign irq_event  = {ap_ready, ap_done};

    assign ap_start     = ap_start_q;
    assign ap_reset     = ap_reset_q;
    assign interrupt    = gie_q & (|isr_q);
    assign ap_ctrl_read = r_fire & r_is_ctrl_q;
    assign dcr_wr_valid = ~fifo_empty;
    assign dcr_wr_addr  = fifo_empty ? '0 : fifo_addr[rd_ptr[PW-1:0]];
    assign dcr_wr_data  = fifo_empty ? '0 : fifo_data[rd_ptr[PW-1:0]];

    for (genvar gi = 0; gi < NUM_USER_REGS; gi++) begin : g_user_out
        assign user_regs[64*gi +: 64] = user_q[gi];
    end

    // Decode the held write address: writable registers answer OKAY, all else SLVERR
    always_comb begin
        wr_ok   = 1'b0;
        wr_user = 1'b0;
        case (aw_addr_q)
            8'h00, 8'h04, 8'h08, 8'h0C, 8'h20, 8'h24: wr_ok = 1'b1;
            default: begin
                wr_user = (aw_addr_q[7:6] == 2'b01) && (aw_addr_q[1:0] == 2'b00) &&
                          ({1'b0, aw_addr_q[5:3]} < NUM_UR);
                wr_ok   = wr_user;
            end
        endcase
    end

    // Read mux; status fields are sampled in the AR handshake cycle
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (ar_addr)
            8'h00: rd_data = {24'b0, auto_restart_q, 3'b000, ap_ready, ap_idle, done_q, ap_start_q};
            8'h04: rd_data = {31'b0, gie_q};
            8'h08: rd_data = {30'b0, ier_q};
            8'h0C: rd_data = {30'b0, isr_q};
            8'h10: rd_data = dev_caps[31:0];
            8'h14: rd_data = dev_caps[63:32];
            8'h18: rd_data = isa_caps[31:0];
            8'h1C: rd_data = isa_caps[63:32];
            8'h20: rd_data = 32'(dcr_addr_q);
            8'h28: rd_data = {14'b0, fifo_full, fifo_empty, 16'(fifo_count)};
            default: begin
                if ((ar_addr[7:6] == 2'b01) && (ar_addr[1:0] == 2'b00) &&
                    ({1'b0, ar_addr[5:3]} < NUM_UR)) begin
                    for (int i = 0; i < NUM_USER_REGS; i++) begin
                        if (ar_addr[5:3] == 3'(i)) begin
                            rd_data = ar_addr[2] ? user_q[i][63:32] : user_q[i][31:0];
                        end
                    end
                end else begin
                    rd_err = 1'b1;
                end
            end
        endcase
    end

    // Queue storage; outputs are gated by empty so stale entries never leak out
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PW-1:0]] <= dcr_addr_q;
            fifo_data[wr_ptr[PW-1:0]] <= w_data_q[VX_DCR_DATA_WIDTH-1:0];
        end
    end

    // Channel state, register file, kernel control and interrupt status
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held <= 1'b0;  w_held <= 1'b0;  aw_addr_q <= '0;
            w_data_q <= '0;   w_strb_q <= '0;
            bvalid_q <= 1'b0; bresp_q <= OKAY;
            rvalid_q <= 1'b0; rdata_q <= '0;   rresp_q <= OKAY;
            r_is_ctrl_q <= 1'b0; r_ctrl_done_q <= 1'b0;
            ap_start_q <= 1'b0; auto_restart_q <= 1'b0; done_q <= 1'b0; ap_reset_q <= 1'b0;
            gie_q <= 1'b0; ier_q <= '0; isr_q <= '0; dcr_addr_q <= '0;
            wr_ptr <= '0; rd_ptr <= '0;
            for (int i = 0; i < NUM_USER_REGS; i++) user_q[i] <= '0;
        end else begin
            ap_reset_q <= 1'b0;
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi.awaddr[7:0];
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
            if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
            if (ap_ready && !auto_restart_q) ap_start_q <= 1'b0;
            if (r_fire && r_ctrl_done_q) done_q <= 1'b0;
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? OKAY : SLVERR;
                case (aw_addr_q)
                    8'h00: begin
                        if (w_data_q[0]) ap_start_q <= 1'b1;
                        auto_restart_q <= w_data_q[7];
                        if (w_data_q[4]) begin
                            ap_reset_q <= 1'b1;
                            ap_start_q <= 1'b0;
                            done_q     <= 1'b0;
                            rd_ptr     <= wr_ptr;
                        end
                    end
                    8'h04: gie_q <= w_data_q[0];
                    8'h08: ier_q <= w_data_q[1:0];
                    8'h0C: isr_q <= isr_q ^ w_data_q[1:0];
                    8'h20: dcr_addr_q <= w_data_q[VX_DCR_ADDR_WIDTH-1:0];
                    8'h24: wr_ptr <= wr_ptr + 1'b1;
                    default: ;
                endcase
                for (int i = 0; i < NUM_USER_REGS; i++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_user && aw_addr_q[5:3] == 3'(i) && w_strb_q[b]) begin
                            if (aw_addr_q[2]) user_q[i][32 + 8*b +: 8] <= w_data_q[8*b +: 8];
                            else              user_q[i][8*b +: 8]      <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end

            // Event sets are applied last so they win over clears and toggles
            if (ap_done) done_q <= 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (ier_q[k] && irq_event[k]) isr_q[k] <= 1'b1;
            end

            if (ar_fire) begin
                rvalid_q      <= 1'b1;
                rdata_q       <= rd_data;
                rresp_q       <= rd_err ? SLVERR : OKAY;
                r_is_ctrl_q   <= (ar_addr == 8'h00);
                r_ctrl_done_q <= (ar_addr == 8'h00) & done_q;
            end else if (r_fire) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vx_afu_ctrl_queued.sv
// tb/tb_vx_afu_ctrl_queued.sv - directed table-driven bench for vx_afu_ctrl_queued
module tb_vx_afu_ctrl_queued;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic ap_start, ap_reset, ap_done, ap_ready, ap_idle, interrupt, ap_ctrl_read;
    logic [63:0] dev_caps, isa_caps;
    logic dcr_wr_valid, dcr_wr_ready;
    logic [11:0] dcr_wr_addr;
    logic [31:0] dcr_wr_data;
    logic [255:0] user_regs;

    vx_afu_ctrl_queued_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) s_axi ();

    vx_afu_ctrl_queued #(
        .S_AXI_ADDR_WIDTH(8), .S_AXI_DATA_WIDTH(32), .DCR_FIFO_DEPTH(4),
        .NUM_USER_REGS(4), .VX_DCR_ADDR_WIDTH(12), .VX_DCR_DATA_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .s_axi(s_axi),
        .ap_start(ap_start), .ap_reset(ap_reset), .ap_done(ap_done), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .interrupt(interrupt), .ap_ctrl_read(ap_ctrl_read),
        .dev_caps(dev_caps), .isa_caps(isa_caps),
        .dcr_wr_valid(dcr_wr_valid), .dcr_wr_ready(dcr_wr_ready),
        .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data), .user_regs(user_regs)
    );

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    int checks = 0;
    int errors = 0;
    int ctrl_read_cnt = 0;
    int ap_reset_cnt = 0;
    logic [11:0] got_addr [$];
    logic [31:0] got_data [$];

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t vq [$];

    always @(negedge clk) begin
        if (ap_ctrl_read) ctrl_read_cnt++;
        if (ap_reset) ap_reset_cnt++;
        if (dcr_wr_valid && dcr_wr_ready) begin
            got_addr.push_back(dcr_wr_addr);
            got_data.push_back(dcr_wr_data);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic add(input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] r, input logic [31:0] rd);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = rd;
        vq.push_back(v);
    endtask

    task automatic start_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0;
        bit w_done = 0;
        s_axi.awaddr = a; s_axi.wdata = d; s_axi.wstrb = s;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
            bit aw_go, w_go;
            @(negedge clk);
            aw_go = s_axi.awvalid & s_axi.awready;
            w_go  = s_axi.wvalid & s_axi.wready;
            @(posedge clk); #1;
            if (aw_go) begin s_axi.awvalid = 1'b0; aw_done = 1; end
            if (w_go)  begin s_axi.wvalid = 1'b0;  w_done = 1; end
        end
        if (!(aw_done && w_done)) begin
            timeout("aw_w_accept");
            s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        end
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit got = 0;
        resp = 2'bxx;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (s_axi.bvalid) begin got = 1; resp = s_axi.bresp; end
        end
        if (!got) timeout("bvalid");
        else begin @(posedge clk); #1; end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        start_write(a, d, s);
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit go = 0;
        bit got = 0;
        d = 'x; resp = 2'bxx;
        s_axi.araddr = a; s_axi.arvalid = 1'b1;
        for (int n = 0; n < 50 && !go; n++) begin
            @(negedge clk);
            go = s_axi.arready;
            @(posedge clk); #1;
        end
        s_axi.arvalid = 1'b0;
        if (!go) begin timeout("arready"); return; end
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (s_axi.rvalid) begin got = 1; d = s_axi.rdata; resp = s_axi.rresp; end
        end
        if (!got) timeout("rvalid");
        else begin @(posedge clk); #1; end
    endtask

    task automatic pulse_done();
        ap_done = 1'b1;
        @(posedge clk); #1;
        ap_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int c0;
        bit ok;

        reset = 1'b1;
        ap_done = 0; ap_ready = 0; ap_idle = 1'b1; dcr_wr_ready = 1'b0;
        dev_caps = 64'h1122_3344_5566_7788;
        isa_caps = 64'h99AA_BBCC_DDEE_FF00;
        s_axi.awvalid = 0; s_axi.awaddr = '0; s_axi.wvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0;
        s_axi.bready = 1'b1; s_axi.arvalid = 0; s_axi.araddr = '0; s_axi.rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_readies", {s_axi.awready, s_axi.wready, s_axi.arready}, 0);
        check("reset_outputs", {s_axi.bvalid, s_axi.rvalid, ap_start, ap_reset, interrupt,
                                dcr_wr_valid, ap_ctrl_read}, 0);
        check("reset_user_regs", {63'b0, |user_regs}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_awready", s_axi.awready, 1);

        // W leads AW by three cycles; partial strobe keeps the low two bytes only
        @(posedge clk); #1;
        s_axi.wdata = 32'hDEAD_BEEF; s_axi.wstrb = 4'h3; s_axi.wvalid = 1'b1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = s_axi.wready; end
        @(posedge clk); #1;
        s_axi.wvalid = 1'b0;
        @(negedge clk);
        check("w_held_blocks_wready", s_axi.wready, 0);
        @(posedge clk);
        @(posedge clk); #1;
        s_axi.awaddr = 8'h40; s_axi.awvalid = 1'b1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = s_axi.awready; end
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0;
        wait_b(resp);
        check("split_w_aw_bresp", resp, OKAY);
        check("split_user0_lo", user_regs[31:0], 32'h0000_BEEF);
        axi_read(8'h40, rd, resp);
        check("split_read_40", rd, 32'h0000_BEEF);

        // Register-map vectors
        add(0, 8'h00, 0, 0, OKAY, 32'h0000_0004);
        add(0, 8'h10, 0, 0, OKAY, 32'h5566_7788);
        add(0, 8'h14, 0, 0, OKAY, 32'h1122_3344);
        add(0, 8'h18, 0, 0, OKAY, 32'hDDEE_FF00);
        add(0, 8'h1C, 0, 0, OKAY, 32'h99AA_BBCC);
        add(1, 8'h04, 32'h1, 4'hF, OKAY, 0);
        add(0, 8'h04, 0, 0, OKAY, 32'h1);
        add(1, 8'h08, 32'h3, 4'hF, OKAY, 0);
        add(0, 8'h08, 0, 0, OKAY, 32'h3);
        add(1, 8'h08, 32'h1, 4'hF, OKAY, 0);
        add(0, 8'h0C, 0, 0, OKAY, 32'h0);
        add(1, 8'h44, 32'hCAFE_F00D, 4'hF, OKAY, 0);
        add(0, 8'h44, 0, 0, OKAY, 32'hCAFE_F00D);
        add(1, 8'h48, 32'h1234_5678, 4'hC, OKAY, 0);
        add(0, 8'h48, 0, 0, OKAY, 32'h1234_0000);
        add(1, 8'h60, 32'h1, 4'hF, SLVERR, 0);
        add(0, 8'h60, 0, 0, SLVERR, 32'h0);
        add(0, 8'h24, 0, 0, SLVERR, 32'h0);
        add(1, 8'h28, 32'h1, 4'hF, SLVERR, 0);
        add(1, 8'h10, 32'hFFFF_FFFF, 4'hF, SLVERR, 0);
        add(0, 8'h10, 0, 0, OKAY, 32'h5566_7788);
        add(0, 8'h30, 0, 0, SLVERR, 32'h0);
        add(1, 8'h20, 32'hABC, 4'hF, OKAY, 0);
        add(0, 8'h20, 0, 0, OKAY, 32'hABC);
        add(0, 8'h28, 0, 0, OKAY, 32'h0001_0000);
        add(0, 8'h41, 0, 0, SLVERR, 32'h0);
        add(1, 8'h5C, 32'h1, 4'hF, OKAY, 0);
        add(0, 8'h5C, 0, 0, OKAY, 32'h1);
        foreach (vq[i]) begin
            if (vq[i].wr) begin
                axi_write(vq[i].addr, vq[i].data, vq[i].strb, resp);
                check($sformatf("vec%0d_w%02h_bresp", i, vq[i].addr), resp, vq[i].resp);
            end else begin
                axi_read(vq[i].addr, rd, resp);
                check($sformatf("vec%0d_r%02h_rresp", i, vq[i].addr), resp, vq[i].resp);
                check($sformatf("vec%0d_r%02h_rdata", i, vq[i].addr), rd, vq[i].rdata);
            end
        end
        check("user_regs_0", user_regs[63:0], 64'hCAFE_F00D_0000_BEEF);
        check("user_regs_1", user_regs[127:64], 64'h0000_0000_1234_0000);
        check("user_regs_3", user_regs[255:192], 64'h0000_0001_0000_0000);

        // DCR queue fills, fifth push stalls, then drains in order
        for (int i = 0; i < 4; i++) begin
            axi_write(8'h20, 32'h100 + i, 4'hF, resp);
            axi_write(8'h24, 32'hD000_0000 + i, 4'hF, resp);
            check($sformatf("dcr_push%0d_bresp", i), resp, OKAY);
        end
        axi_write(8'h20, 32'h104, 4'hF, resp);
        start_write(8'h24, 32'hD000_0004, 4'hF);
        ok = 1;
        for (int n = 0; n < 4; n++) begin @(negedge clk); if (s_axi.bvalid) ok = 0; end
        check("dcr_full_stall_no_bvalid", ok, 1);
        check("dcr_full_stall_awready", s_axi.awready, 0);
        @(posedge clk); #1;
        axi_read(8'h28, rd, resp);
        check("dcr_status_full", rd, 32'h0002_0004);
        dcr_wr_ready = 1'b1;
        wait_b(resp);
        check("dcr_push4_bresp", resp, OKAY);
        ok = 0;
        for (int n = 0; n < 30 && !ok; n++) begin @(negedge clk); ok = !dcr_wr_valid; end
        if (!ok) timeout("dcr_drain");
        check("dcr_drain_count", got_addr.size(), 5);
        for (int i = 0; i < 5 && i < got_addr.size(); i++) begin
            check($sformatf("dcr_drain%0d_addr", i), got_addr[i], 12'h100 + 12'(i));
            check($sformatf("dcr_drain%0d_data", i), got_data[i], 32'hD000_0000 + 32'(i));
        end
        @(posedge clk); #1;
        axi_read(8'h28, rd, resp);
        check("dcr_status_empty", rd, 32'h0001_0000);
        dcr_wr_ready = 1'b0;

        // Done latch, clear-on-read and interrupt (GIE=1, IER=1 from the table)
        pulse_done();
        @(negedge clk);
        check("irq_after_done", interrupt, 1);
        @(posedge clk); #1;
        c0 = ctrl_read_cnt;
        axi_read(8'h00, rd, resp);
        check("ctrl_read_done_set", rd, 32'h0000_0006);
        axi_read(8'h00, rd, resp);
        check("ctrl_read_done_clear", rd, 32'h0000_0004);
        check("ap_ctrl_read_pulses", ctrl_read_cnt - c0, 2);
        axi_write(8'h0C, 32'h1, 4'hF, resp);
        @(negedge clk);
        check("irq_cleared_by_isr_toggle", interrupt, 0);
        @(posedge clk); #1;

        // auto_restart keeps ap_start; without it ap_ready clears ap_start
        axi_write(8'h00, 32'h81, 4'hF, resp);
        ap_ready = 1'b1; @(posedge clk); #1; ap_ready = 1'b0;
        @(negedge clk);
        check("auto_restart_keeps_start", ap_start, 1);
        @(posedge clk); #1;
        axi_write(8'h00, 32'h01, 4'hF, resp);
        ap_ready = 1'b1; @(posedge clk); #1; ap_ready = 1'b0;
        @(negedge clk);
        check("ap_ready_clears_start", ap_start, 0);
        @(posedge clk); #1;
        axi_write(8'h00, 32'h81, 4'hF, resp);
        axi_write(8'h24, 32'h42, 4'hF, resp);
        @(negedge clk);
        check("dcr_head_valid", {dcr_wr_valid, dcr_wr_addr, dcr_wr_data}, {1'b1, 12'h104, 32'h42});
        @(posedge clk); #1;
        c0 = ap_reset_cnt;
        axi_write(8'h00, 32'h10, 4'hF, resp);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ap_reset_one_cycle", ap_reset_cnt - c0, 1);
        check("ap_reset_clears_start", ap_start, 0);
        check("ap_reset_flushes_fifo", dcr_wr_valid, 0);
        @(posedge clk); #1;

        // Reset while a response and a queue entry are pending
        pulse_done();
        axi_write(8'h24, 32'h77, 4'hF, resp);
        s_axi.bready = 1'b0;
        start_write(8'h04, 32'h1, 4'hF);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = s_axi.bvalid; end
        check("pre_reset_state", {s_axi.bvalid, dcr_wr_valid, interrupt}, 3'b111);
        @(posedge clk); #1;
        reset = 1'b1;
        s_axi.awvalid = 1'b1; s_axi.arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_drops_state", {s_axi.bvalid, dcr_wr_valid, interrupt}, 0);
        ok = 1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (s_axi.awready || s_axi.wready || s_axi.arready || s_axi.rvalid) ok = 0;
        end
        check("readies_low_in_reset", ok, 1);
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0; s_axi.arvalid = 1'b0;
        reset = 1'b0;
        s_axi.bready = 1'b1;
        @(negedge clk);
        check("after_reset_ready", {s_axi.awready, s_axi.bvalid}, 2'b10);
        @(posedge clk); #1;
        axi_read(8'h28, rd, resp);
        check("after_reset_fifo_empty", rd, 32'h0001_0000);
        axi_read(8'h04, rd, resp);
        check("after_reset_gie", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
